mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Byte-wide memory bus arbiter: grants one of NUM_M masters onto a shared RAM/IO bus,
// returns read data one cycle after the access, and supports button-driven single-stepping.
module mem_bus_arbiter #(
  parameter int NUM_M          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int ARB_MODE       = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_M-1:0]              m_req,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   m_a,
  input  logic [NUM_M-1:0]              m_wr,
  input  logic [NUM_M*8-1:0]            m_wdata,
  output logic [NUM_M-1:0]              m_ack,
  output logic [NUM_M-1:0]              m_rvalid,
  output logic [7:0]                    m_rdata,
  output logic                          bus_wr,
  output logic [7:0]                    bus_wdata,
  output logic                          ram_en,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_a,
  input  logic [7:0]                    ram_rdata,
  output logic                          io_en,
  output logic [2:0]                    io_sel,
  input  logic [7:0]                    io_rdata,
  input  logic                          io_full,
  input  logic                          step_en,
  input  logic                          step_btn
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SEL_W = RAM_ADDR_WIDTH + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [NUM_M-1:0]   gnt, gnt_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]   arb_base;
  logic [IDX_W:0]     arb;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;

  logic [SEL_W-1:0]   g_addr;
  logic [7:0]         g_wdata;
  logic               g_req;
  logic               g_wr;
  logic               io_hit;
  logic               stall;
  logic               fire;

  logic [NUM_M-1:0]   rvalid;
  logic               src_io;
  logic [2:0]         sync_q;
  logic               step_pulse;
  logic               step_token;
  logic               addr_unused;

  // Search starts at base and wraps; iterating downwards leaves the nearest requester in res.
  function automatic logic [IDX_W:0] pick_winner(input logic [NUM_M-1:0] req,
                                                 input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(base) + k) % NUM_M);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_M-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_M-1:0] oh;
    for (int i = 0; i < NUM_M; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_M - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Only the low address bits reach the bus; the rest are consumed here.
  assign addr_unused = ^m_a;

  // Granted-master mux (gnt is one-hot or zero).
  always_comb begin
    g_req   = |(gnt & m_req);
    g_wr    = |(gnt & m_wr);
    g_addr  = '0;
    g_wdata = 8'h00;
    for (int i = 0; i < NUM_M; i++) begin
      g_addr  = g_addr  | ({SEL_W{gnt[i]}} & m_a[i*ADDR_WIDTH +: SEL_W]);
      g_wdata = g_wdata | ({8{gnt[i]}} & m_wdata[i*8 +: 8]);
    end
  end

  // Arbitration winner among current requesters.
  always_comb begin
    arb_base  = (ARB_MODE == 1) ? rr_ptr : '0;
    arb       = pick_winner(m_req, arb_base);
    win_valid = arb[IDX_W];
    win_idx   = arb[IDX_W-1:0];
  end

  // Access qualification: IO writes wait for buffer space, step mode waits for a token.
  always_comb begin
    io_hit = (g_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
    stall  = (step_en & ~step_token) | (io_hit & g_wr & io_full);
    fire   = (state == BUSY) & g_req & ~stall;
  end

  // Next-state, grant and round-robin pointer.
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_next  = BUSY;
          gnt_next    = to_onehot(win_idx);
          rr_ptr_next = next_ptr(win_idx);
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      BUSY: begin
        if (g_req) begin
          state_next = BUSY;
          gnt_next   = gnt;
        end else if (win_valid) begin
          state_next  = BUSY;
          gnt_next    = to_onehot(win_idx);
          rr_ptr_next = next_ptr(win_idx);
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Read return: remember which master and which source to present next cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rvalid <= '0;
      src_io <= 1'b0;
    end else if (fire && !g_wr) begin
      rvalid <= gnt;
      src_io <= io_hit;
    end else begin
      rvalid <= '0;
      src_io <= src_io;
    end
  end

  // Step button synchroniser.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], step_btn};
    end
  end

  assign step_pulse = sync_q[1] & ~sync_q[2];

  // A new press wins over the access that consumes the previous token.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      step_token <= 1'b0;
    end else if (!step_en) begin
      step_token <= 1'b0;
    end else if (step_pulse) begin
      step_token <= 1'b1;
    end else if (fire) begin
      step_token <= 1'b0;
    end else begin
      step_token <= step_token;
    end
  end

  assign m_ack     = fire ? gnt : '0;
  assign ram_en    = fire & ~io_hit;
  assign io_en     = fire & io_hit;
  assign bus_wr    = fire & g_wr;
  assign bus_wdata = fire ? g_wdata : 8'h00;
  assign ram_a     = g_addr[RAM_ADDR_WIDTH-1:0];
  assign io_sel    = g_addr[2:0];
  assign m_rvalid  = rvalid;
  assign m_rdata   = (|rvalid) ? (src_io ? io_rdata : ram_rdata) : 8'h00;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share stimulus.
module tb_mem_bus_arbiter;

  logic        clk_in, rst_in;
  logic [1:0]  m_req, m_wr;
  logic [63:0] m_a;
  logic [15:0] m_wdata;
  logic [7:0]  ram_rdata, io_rdata;
  logic        io_full, step_en, step_btn;

  logic [1:0]  a_m_ack, a_m_rvalid, b_m_ack, b_m_rvalid;
  logic [7:0]  a_m_rdata, a_bus_wdata, b_m_rdata, b_bus_wdata;
  logic        a_bus_wr, a_ram_en, a_io_en, b_bus_wr, b_ram_en, b_io_en;
  logic [16:0] a_ram_a, b_ram_a;
  logic [2:0]  a_io_sel, b_io_sel;

  int checks = 0;
  int fails  = 0;

  mem_bus_arbiter #(.NUM_M(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .ARB_MODE(0)) dut_fixed (
    .clk_in(clk_in), .rst_in(rst_in), .m_req(m_req), .m_a(m_a), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_ack(a_m_ack), .m_rvalid(a_m_rvalid), .m_rdata(a_m_rdata), .bus_wr(a_bus_wr),
    .bus_wdata(a_bus_wdata), .ram_en(a_ram_en), .ram_a(a_ram_a), .ram_rdata(ram_rdata),
    .io_en(a_io_en), .io_sel(a_io_sel), .io_rdata(io_rdata), .io_full(io_full),
    .step_en(step_en), .step_btn(step_btn));

  mem_bus_arbiter #(.NUM_M(2), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .ARB_MODE(1)) dut_rr (
    .clk_in(clk_in), .rst_in(rst_in), .m_req(m_req), .m_a(m_a), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_ack(b_m_ack), .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata), .bus_wr(b_bus_wr),
    .bus_wdata(b_bus_wdata), .ram_en(b_ram_en), .ram_a(b_ram_a), .ram_rdata(ram_rdata),
    .io_en(b_io_en), .io_sel(b_io_sel), .io_rdata(io_rdata), .io_full(io_full),
    .step_en(step_en), .step_btn(step_btn));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; m_req = 2'b11; m_wr = 2'b00; m_a = 64'h0; m_wdata = 16'h0;
    ram_rdata = 8'h5A; io_rdata = 8'h00; io_full = 1'b0; step_en = 1'b0; step_btn = 1'b0;
    repeat (3) cyc();
    smp();
    checks++; if (a_m_ack !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b expected 00", a_m_ack); end
    checks++; if ({a_ram_en, a_io_en, a_bus_wr} !== 3'b000) begin fails++; $display("FAIL reset_en: got %b expected 000", {a_ram_en, a_io_en, a_bus_wr}); end
    checks++; if (a_m_rvalid !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", a_m_rvalid); end
    checks++; if (a_m_rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", a_m_rdata); end
    checks++;
    if ({b_m_ack, b_m_rvalid, b_m_rdata, b_bus_wr, b_bus_wdata, b_ram_en, b_ram_a, b_io_en, b_io_sel} !== 42'h0) begin
      fails++; $display("FAIL reset_rr_outputs: got %h expected 0",
        {b_m_ack, b_m_rvalid, b_m_rdata, b_bus_wr, b_bus_wdata, b_ram_en, b_ram_a, b_io_en, b_io_sel});
    end
    cyc(); m_req = 2'b00;
    cyc(); rst_in = 1'b0;
    cyc();
  endtask

  task automatic test_fixed_priority();
    m_a = {32'h0000_0024, 32'h0000_0014}; m_wr = 2'b00; m_req = 2'b11;
    smp();
    checks++; if (a_m_ack !== 2'b00) begin fails++; $display("FAIL fp_idle: got %b expected 00", a_m_ack); end
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL fp_first: got %b expected 01", a_m_ack); end
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL fp_locked: got %b expected 01", a_m_ack); end
    cyc(); m_req = 2'b10; smp();
    checks++; if (a_m_ack !== 2'b00) begin fails++; $display("FAIL fp_drop: got %b expected 00", a_m_ack); end
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b10) begin fails++; $display("FAIL fp_m1: got %b expected 10", a_m_ack); end
    cyc(); m_req = 2'b00;
    repeat (2) cyc();
  endtask

  task automatic test_round_robin();
    int seq[$];
    int got;
    logic [1:0] ack;
    m_a = {32'h0000_0034, 32'h0000_0030}; m_wr = 2'b00; m_req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      smp();
      ack = b_m_ack;
      if (ack == 2'b01) seq.push_back(0);
      else if (ack == 2'b10) seq.push_back(1);
      else if (ack == 2'b11) seq.push_back(2);
      cyc();
      m_req = ~ack;
    end
    m_req = 2'b00;
    repeat (3) cyc();
    for (int k = 0; k < 4; k++) begin
      got = (k < seq.size()) ? seq[k] : -1;
      checks++; if (got !== (k % 2)) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got, k % 2); end
    end
  endtask

  task automatic test_rr_pointer();
    m_req = 2'b01;
    cyc(); smp();
    checks++; if (b_m_ack !== 2'b01) begin fails++; $display("FAIL rrp_single: got %b expected 01", b_m_ack); end
    cyc(); m_req = 2'b00;
    cyc(); m_req = 2'b11;
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL rrp_fixed: got %b expected 01", a_m_ack); end
    checks++; if (b_m_ack !== 2'b10) begin fails++; $display("FAIL rrp_rotate: got %b expected 10", b_m_ack); end
    cyc(); m_req = 2'b00;
    repeat (2) cyc();
  endtask

  task automatic test_ram_read();
    m_a[31:0] = 32'h0000_0010; m_wr = 2'b00; ram_rdata = 8'hA5; m_req = 2'b01;
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL rd_ack: got %b expected 01", a_m_ack); end
    checks++; if (a_ram_a !== 17'h00010) begin fails++; $display("FAIL rd_ram_a: got %h expected 00010", a_ram_a); end
    checks++; if ({a_ram_en, a_io_en, a_bus_wr} !== 3'b100) begin fails++; $display("FAIL rd_strobes: got %b expected 100", {a_ram_en, a_io_en, a_bus_wr}); end
    cyc(); m_req = 2'b00; smp();
    checks++; if (a_m_rvalid !== 2'b01) begin fails++; $display("FAIL rd_rvalid: got %b expected 01", a_m_rvalid); end
    checks++; if (a_m_rdata !== 8'hA5) begin fails++; $display("FAIL rd_rdata: got %h expected a5", a_m_rdata); end
    cyc(); smp();
    checks++; if ({a_m_rvalid, a_m_rdata} !== 10'h000) begin fails++; $display("FAIL rd_after: got %h expected 000", {a_m_rvalid, a_m_rdata}); end
    cyc();
  endtask

  task automatic test_back_to_back();
    m_a[31:0] = 32'h0000_0020; m_req = 2'b01;
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL b2b_ack1: got %b expected 01", a_m_ack); end
    cyc(); ram_rdata = 8'h11; smp();
    checks++; if ({a_m_ack, a_m_rvalid, a_m_rdata} !== {2'b01, 2'b01, 8'h11}) begin
      fails++; $display("FAIL b2b_second: got %h expected 511", {a_m_ack, a_m_rvalid, a_m_rdata});
    end
    cyc(); m_req = 2'b00; ram_rdata = 8'h22; smp();
    checks++; if ({a_m_ack, a_m_rvalid, a_m_rdata} !== {2'b00, 2'b01, 8'h22}) begin
      fails++; $display("FAIL b2b_last: got %h expected 122", {a_m_ack, a_m_rvalid, a_m_rdata});
    end
    cyc(); smp();
    checks++; if (a_m_rvalid !== 2'b00) begin fails++; $display("FAIL b2b_end: got %b expected 00", a_m_rvalid); end
    cyc();
  endtask

  task automatic test_io_read();
    m_a[31:0] = 32'h0003_0005; io_full = 1'b1; io_rdata = 8'h3C; ram_rdata = 8'hA5; m_req = 2'b01;
    cyc(); smp();
    checks++; if ({a_m_ack, a_io_en, a_ram_en, a_io_sel} !== {2'b01, 1'b1, 1'b0, 3'd5}) begin
      fails++; $display("FAIL io_rd_issue: got %b expected 0110101", {a_m_ack, a_io_en, a_ram_en, a_io_sel});
    end
    cyc(); m_req = 2'b00; smp();
    checks++; if ({a_m_rvalid, a_m_rdata} !== {2'b01, 8'h3C}) begin
      fails++; $display("FAIL io_rd_data: got %h expected 13c", {a_m_rvalid, a_m_rdata});
    end
    cyc(); io_full = 1'b0;
    cyc();
  endtask

  task automatic test_io_write();
    m_a[63:32] = 32'h0003_0000; m_wr = 2'b10; m_wdata = 16'h4100; io_full = 1'b1; m_req = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      cyc(); smp();
      checks++; if ({a_io_en, a_m_ack, a_bus_wr, a_bus_wdata} !== 12'h000) begin
        fails++; $display("FAIL io_wr_stall[%0d]: got %h expected 000", c, {a_io_en, a_m_ack, a_bus_wr, a_bus_wdata});
      end
    end
    cyc(); io_full = 1'b0; smp();
    checks++; if ({a_io_en, a_ram_en, a_io_sel, a_bus_wr, a_bus_wdata, a_m_ack} !== {1'b1, 1'b0, 3'd0, 1'b1, 8'h41, 2'b10}) begin
      fails++; $display("FAIL io_wr_fire: got %b expected 1000101000001_10",
        {a_io_en, a_ram_en, a_io_sel, a_bus_wr, a_bus_wdata, a_m_ack});
    end
    cyc(); m_req = 2'b00; m_wr = 2'b00; smp();
    checks++; if (a_m_rvalid !== 2'b00) begin fails++; $display("FAIL io_wr_no_rvalid: got %b expected 00", a_m_rvalid); end
    repeat (2) cyc();
  endtask

  task automatic test_single_step();
    int cnt = 0;
    int t1 = -100;
    int t2 = -100;
    step_en = 1'b1; m_a[63:32] = 32'h0000_0040; m_wr = 2'b00; m_req = 2'b10;
    for (int c = 0; c < 30; c++) begin
      step_btn = ((c >= 3 && c < 8) || (c >= 13 && c < 18)) ? 1'b1 : 1'b0;
      smp();
      if (a_m_ack[1]) begin
        cnt++;
        if (cnt == 1) t1 = c;
        else if (cnt == 2) t2 = c;
      end
      cyc();
    end
    step_en = 1'b0; step_btn = 1'b0; m_req = 2'b00;
    repeat (2) cyc();
    checks++; if (cnt !== 2) begin fails++; $display("FAIL step_count: got %0d expected 2", cnt); end
    checks++; if (t1 - 3 < 3 || t1 - 3 > 4) begin fails++; $display("FAIL step_delay1: got %0d expected 3..4", t1 - 3); end
    checks++; if (t2 - 13 < 3 || t2 - 13 > 4) begin fails++; $display("FAIL step_delay2: got %0d expected 3..4", t2 - 13); end
  endtask

  task automatic test_reset_mid_read();
    m_a[31:0] = 32'h0000_0010; m_wr = 2'b00; ram_rdata = 8'h77; m_req = 2'b01;
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL rst_ack: got %b expected 01", a_m_ack); end
    rst_in = 1'b1; m_req = 2'b00;
    #1;
    checks++; if ({a_m_ack, a_ram_en, a_bus_wr} !== 4'b0000) begin fails++; $display("FAIL rst_async: got %b expected 0000", {a_m_ack, a_ram_en, a_bus_wr}); end
    cyc(); smp();
    checks++; if ({a_m_rvalid, a_m_rdata} !== 10'h000) begin fails++; $display("FAIL rst_no_rvalid: got %h expected 000", {a_m_rvalid, a_m_rdata}); end
    cyc(); rst_in = 1'b0; m_req = 2'b01; smp();
    checks++; if (a_m_ack !== 2'b00) begin fails++; $display("FAIL rst_idle: got %b expected 00", a_m_ack); end
    cyc(); smp();
    checks++; if (a_m_ack !== 2'b01) begin fails++; $display("FAIL rst_recover: got %b expected 01", a_m_ack); end
    cyc(); m_req = 2'b00;
    repeat (2) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_rr_pointer();
    test_ram_read();
    test_back_to_back();
    test_io_read();
    test_io_write();
    test_single_step();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
